// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: decoded control word, operand
// selects, buffered result entry and the skid-buffer occupancy states.
package alu_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int RD_W_DEFAULT   = 5;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {
    OP_REG,
    OP_IMM,
    OP_PC,
    OP_ZERO
  } op_sel_e;

  typedef struct packed {
    alu_op_e operation;
    op_sel_e op1_sel;
    op_sel_e op2_sel;
    logic    use_unsigned;
  } alu_control_t;

  // Buffer entries hold finished results, so the field widths are fixed here.
  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] result;
    logic [RD_W_DEFAULT-1:0]   rd;
    logic                      zero;
    logic                      neg;
    logic                      ovf;
  } ex_result_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } occ_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result plus zero/negative/overflow flags.
// Overflow is carry/borrow or signed overflow for ADD/SUB, zero otherwise.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  alu_control_t      ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   add_ext;
  logic [DATA_W:0]   sub_ext;
  logic [SH_W-1:0]   shamt;

  assign add_ext = {1'b0, op1} + {1'b0, op2};
  assign sub_ext = {1'b0, op1} - {1'b0, op2};
  assign shamt   = op2[SH_W-1:0];

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    unique case (ctrl.operation)
      ALU_ADD: begin
        result = add_ext[DATA_W-1:0];
        ovf    = ctrl.use_unsigned ? add_ext[DATA_W]
               : ((op1[DATA_W-1] == op2[DATA_W-1]) && (result[DATA_W-1] != op1[DATA_W-1]));
      end
      ALU_SUB: begin
        result = sub_ext[DATA_W-1:0];
        // The extra MSB of the widened difference is the unsigned borrow.
        ovf    = ctrl.use_unsigned ? sub_ext[DATA_W]
               : ((op1[DATA_W-1] != op2[DATA_W-1]) && (result[DATA_W-1] != op1[DATA_W-1]));
      end
      ALU_AND: result = op1 & op2;
      ALU_OR:  result = op1 | op2;
      ALU_XOR: result = op1 ^ op2;
      ALU_SLL: result = op1 << shamt;
      ALU_SRL: result = op1 >> shamt;
      ALU_SRA: result = $unsigned($signed(op1) >>> shamt);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[DATA_W-1];

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: operand select, ALU, and a 2-entry skid buffer of finished
// results between valid/ready handshakes, with registered in_ready.
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int RD_W   = RD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_control_t      in_ctrl,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_ovf
);

  occ_e       state_q, state_d;
  ex_result_t main_q, main_d;
  ex_result_t skid_q, skid_d;
  logic       in_ready_q;

  logic [DATA_W-1:0] op1, op2;
  ex_result_t        res_in;
  logic              in_fire, out_fire;

  function automatic logic [DATA_W-1:0] sel_operand(
    input op_sel_e           sel,
    input logic [DATA_W-1:0] reg_val,
    input logic [DATA_W-1:0] imm,
    input logic [DATA_W-1:0] pc
  );
    unique case (sel)
      OP_REG:  return reg_val;
      OP_IMM:  return imm;
      OP_PC:   return pc;
      default: return '0;
    endcase
  endfunction

  assign op1 = sel_operand(in_ctrl.op1_sel, in_rs1, in_imm, in_pc);
  assign op2 = sel_operand(in_ctrl.op2_sel, in_rs2, in_imm, in_pc);

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .op1    (op1),
    .op2    (op2),
    .ctrl   (in_ctrl),
    .result (res_in.result),
    .zero   (res_in.zero),
    .neg    (res_in.neg),
    .ovf    (res_in.ovf)
  );
  assign res_in.rd = in_rd;

  assign in_fire  = in_valid & in_ready_q & ~flush;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = res_in;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = res_in;
        end else if (in_fire) begin
          state_d = ST_TWO;
          skid_d  = res_in;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush only empties the buffer; stale data is hidden by out_valid=0.
    if (flush) state_d = ST_EMPTY;
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; the buffer entries are reset too because cleared data
  // registers are part of the observable reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_result = main_q.result;
  assign out_rd     = main_q.rd;
  assign out_zero   = main_q.zero;
  assign out_neg    = main_q.neg;
  assign out_ovf    = main_q.ovf;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed self-checking bench for ex_alu_stage: reset, arithmetic corners,
// backpressure, full throughput, flush and mid-operation reset.
module tb_ex_alu_stage;
  import alu_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  alu_control_t in_ctrl;
  logic [31:0]  in_rs1, in_rs2, in_imm, in_pc;
  logic [4:0]   in_rd;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_result;
  logic [4:0]   out_rd;
  logic         out_zero, out_neg, out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  // {valid, result, rd, zero, neg, ovf}
  logic [40:0] obs;
  assign obs = {out_valid, out_result, out_rd, out_zero, out_neg, out_ovf};

  ex_alu_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  function automatic alu_control_t mk(alu_op_e op, op_sel_e s1, op_sel_e s2, logic u);
    alu_control_t c;
    c.operation = op; c.op1_sel = s1; c.op2_sel = s2; c.use_unsigned = u;
    return c;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(alu_control_t c, logic [31:0] rs1, logic [31:0] rs2,
                       logic [31:0] imm, logic [31:0] pc, logic [4:0] rd);
    in_valid = 1'b1; in_ctrl = c;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc; in_rd = rd;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_ctrl = mk(ALU_ADD, OP_ZERO, OP_ZERO, 1'b0);
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0; in_rd = '0;
  endtask

  // Issue one op into an empty stage with out_ready=1, return what appears
  // after the accepting edge, then drain.
  task automatic issue_one(alu_control_t c, logic [31:0] rs1, logic [31:0] rs2,
                           logic [31:0] imm, logic [31:0] pc, logic [4:0] rd,
                           output logic [40:0] seen, output logic drained);
    out_ready = 1'b1;
    drive(c, rs1, rs2, imm, pc, rd);
    step();
    seen = obs;
    idle();
    step();
    drained = ~out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; idle();
    step(); step();
    rst = 1'b0;
    n_cmp++;
    if (obs !== {1'b0, 32'h0, 5'h0, 3'b000}) begin
      n_err++; $display("FAIL reset_outputs: got %h exp %h", obs, {1'b0, 32'h0, 5'h0, 3'b000});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b exp 1", in_ready);
    end
  endtask

  task automatic test_arith();
    logic [40:0] s;
    logic        d;
    issue_one(mk(ALU_ADD, OP_REG, OP_REG, 1'b0), 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 5'd3, s, d);
    n_cmp++;
    if (s !== {1'b1, 32'h8000_0000, 5'd3, 3'b011}) begin
      n_err++; $display("FAIL add_signed_ovf: got %h exp %h", s, {1'b1, 32'h8000_0000, 5'd3, 3'b011});
    end
    n_cmp++;
    if (d !== 1'b1) begin
      n_err++; $display("FAIL add_drain: out_valid still set");
    end
    issue_one(mk(ALU_ADD, OP_REG, OP_REG, 1'b1), 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 5'd4, s, d);
    n_cmp++;
    if (s !== {1'b1, 32'h8000_0000, 5'd4, 3'b010}) begin
      n_err++; $display("FAIL add_unsigned_nocarry: got %h exp %h", s, {1'b1, 32'h8000_0000, 5'd4, 3'b010});
    end
    issue_one(mk(ALU_SUB, OP_REG, OP_REG, 1'b1), 32'd5, 32'd7, 32'h0, 32'h0, 5'd5, s, d);
    n_cmp++;
    if (s !== {1'b1, 32'hFFFF_FFFE, 5'd5, 3'b011}) begin
      n_err++; $display("FAIL sub_borrow: got %h exp %h", s, {1'b1, 32'hFFFF_FFFE, 5'd5, 3'b011});
    end
    issue_one(mk(ALU_SUB, OP_REG, OP_REG, 1'b0), 32'd5, 32'd5, 32'h0, 32'h0, 5'd6, s, d);
    n_cmp++;
    if (s !== {1'b1, 32'h0, 5'd6, 3'b100}) begin
      n_err++; $display("FAIL sub_zero: got %h exp %h", s, {1'b1, 32'h0, 5'd6, 3'b100});
    end
    issue_one(mk(ALU_SRA, OP_REG, OP_IMM, 1'b0), 32'h8000_0000, 32'h0, 32'h21, 32'h0, 5'd7, s, d);
    n_cmp++;
    if (s !== {1'b1, 32'hC000_0000, 5'd7, 3'b010}) begin
      n_err++; $display("FAIL sra_shamt_mask: got %h exp %h", s, {1'b1, 32'hC000_0000, 5'd7, 3'b010});
    end
    issue_one(mk(ALU_SRL, OP_REG, OP_IMM, 1'b0), 32'h8000_0000, 32'h0, 32'h1F, 32'h0, 5'd8, s, d);
    n_cmp++;
    if (s !== {1'b1, 32'h1, 5'd8, 3'b000}) begin
      n_err++; $display("FAIL srl_31: got %h exp %h", s, {1'b1, 32'h1, 5'd8, 3'b000});
    end
    issue_one(mk(ALU_SLL, OP_REG, OP_REG, 1'b0), 32'h3, 32'h4, 32'h0, 32'h0, 5'd9, s, d);
    n_cmp++;
    if (s !== {1'b1, 32'h30, 5'd9, 3'b000}) begin
      n_err++; $display("FAIL sll: got %h exp %h", s, {1'b1, 32'h30, 5'd9, 3'b000});
    end
    issue_one(mk(ALU_ADD, OP_PC, OP_IMM, 1'b0), 32'h0, 32'h0, 32'h4, 32'h1000, 5'd10, s, d);
    n_cmp++;
    if (s !== {1'b1, 32'h1004, 5'd10, 3'b000}) begin
      n_err++; $display("FAIL pc_plus_imm: got %h exp %h", s, {1'b1, 32'h1004, 5'd10, 3'b000});
    end
    issue_one(mk(ALU_XOR, OP_ZERO, OP_REG, 1'b0), 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'h0, 5'd11, s, d);
    n_cmp++;
    if (s !== {1'b1, 32'h1234_5678, 5'd11, 3'b000}) begin
      n_err++; $display("FAIL xor_zero_op1: got %h exp %h", s, {1'b1, 32'h1234_5678, 5'd11, 3'b000});
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(mk(ALU_ADD, OP_REG, OP_REG, 1'b0), 32'd1, 32'd2, 32'h0, 32'h0, 5'd1);   // A = 3
    step();
    n_cmp++;
    if ({in_ready, obs} !== {1'b1, 1'b1, 32'd3, 5'd1, 3'b000}) begin
      n_err++; $display("FAIL bp_A_held: got %h exp %h", {in_ready, obs}, {1'b1, 1'b1, 32'd3, 5'd1, 3'b000});
    end
    drive(mk(ALU_OR, OP_REG, OP_REG, 1'b0), 32'hF0, 32'h0F, 32'h0, 32'h0, 5'd2);  // B = FF
    step();
    n_cmp++;
    if ({in_ready, obs} !== {1'b0, 1'b1, 32'd3, 5'd1, 3'b000}) begin
      n_err++; $display("FAIL bp_two_full: got %h exp %h", {in_ready, obs}, {1'b0, 1'b1, 32'd3, 5'd1, 3'b000});
    end
    drive(mk(ALU_AND, OP_REG, OP_REG, 1'b0), 32'hFF00, 32'h0FF0, 32'h0, 32'h0, 5'd3); // C = F00
    step();
    n_cmp++;
    if ({in_ready, obs} !== {1'b0, 1'b1, 32'd3, 5'd1, 3'b000}) begin
      n_err++; $display("FAIL bp_C_stalled: got %h exp %h", {in_ready, obs}, {1'b0, 1'b1, 32'd3, 5'd1, 3'b000});
    end
    out_ready = 1'b1;
    step();   // A delivered, B moves to main, C not yet accepted
    n_cmp++;
    if ({in_ready, obs} !== {1'b1, 1'b1, 32'hFF, 5'd2, 3'b000}) begin
      n_err++; $display("FAIL bp_B_out: got %h exp %h", {in_ready, obs}, {1'b1, 1'b1, 32'hFF, 5'd2, 3'b000});
    end
    step();   // B delivered, C accepted
    idle();
    n_cmp++;
    if ({in_ready, obs} !== {1'b1, 1'b1, 32'hF00, 5'd3, 3'b000}) begin
      n_err++; $display("FAIL bp_C_out: got %h exp %h", {in_ready, obs}, {1'b1, 1'b1, 32'hF00, 5'd3, 3'b000});
    end
    step();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL bp_drained: got %b exp 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(mk(ALU_ADD, OP_REG, OP_IMM, 1'b0), 32'h100, 32'h0, 32'(i), 32'h0, 5'(i + 16));
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_in_ready[%0d]: got %b exp 1", i, in_ready);
      end
      step();
      n_cmp++;
      if (obs !== {1'b1, 32'h100 + 32'(i), 5'(i + 16), 3'b000}) begin
        n_err++; $display("FAIL b2b_out[%0d]: got %h exp %h", i, obs, {1'b1, 32'h100 + 32'(i), 5'(i + 16), 3'b000});
      end
    end
    idle();
    step();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL b2b_drained: got %b exp 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(mk(ALU_ADD, OP_REG, OP_REG, 1'b0), 32'd10, 32'd1, 32'h0, 32'h0, 5'd1);
    step();
    drive(mk(ALU_ADD, OP_REG, OP_REG, 1'b0), 32'd20, 32'd1, 32'h0, 32'h0, 5'd2);
    step();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_setup_two: in_ready got %b exp 0", in_ready);
    end
    drive(mk(ALU_ADD, OP_REG, OP_REG, 1'b0), 32'd30, 32'd1, 32'h0, 32'h0, 5'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL flush_empty: got %b exp 10", {in_ready, out_valid});
    end
    out_ready = 1'b1;
    drive(mk(ALU_SUB, OP_REG, OP_REG, 1'b0), 32'd50, 32'd8, 32'h0, 32'h0, 5'd4);
    step();
    idle();
    n_cmp++;
    if (obs !== {1'b1, 32'd42, 5'd4, 3'b000}) begin
      n_err++; $display("FAIL flush_next_op: got %h exp %h", obs, {1'b1, 32'd42, 5'd4, 3'b000});
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_no_ghost: out_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b0;
    drive(mk(ALU_OR, OP_REG, OP_IMM, 1'b0), 32'hA500, 32'h0, 32'h5A, 32'h0, 5'd9);
    step();
    idle();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== {1'b1, 32'hA55A, 5'd9, 3'b000}) begin
      n_err++; $display("FAIL rst_no_edge: got %h exp %h", obs, {1'b1, 32'hA55A, 5'd9, 3'b000});
    end
    step();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, out_result} !== {2'b10, 32'h0}) begin
      n_err++; $display("FAIL rst_mid_op: got %h exp %h", {in_ready, out_valid, out_result}, {2'b10, 32'h0});
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
